// File: rtl/tscap_pkg.sv
// Shared constants and timestamp layout for the timestamp capture block.
package tscap_pkg;

    localparam int TS_WIDTH   = 32;
    localparam int TS_EPOCH_W = 16;
    localparam int TS_W       = TS_EPOCH_W + TS_WIDTH;

    localparam int         DROP_W   = 8;
    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef struct packed {
        logic [TS_EPOCH_W-1:0] epoch;
        logic [TS_WIDTH-1:0]   count;
    } ts_t;

endpackage

// File: rtl/tscap_fifo.sv
// Synchronous first-word-fall-through FIFO; head is always visible on dout when not empty.
module tscap_fifo #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       level_q;
    logic              do_push, do_pop;

    // Push while full is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && (level_q != '0);
    assign do_push = push && ((level_q != FULL_LVL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_q];
    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/timestamp_capture.sv
// Captures {epoch, count} on rising edges of event_in into a FWFT FIFO drained by valid/ready.
module timestamp_capture
    import tscap_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int EPOCH_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           count,
    input  logic                       overflow,
    input  logic                       event_in,
    input  logic                       cap_en,
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic [EPOCH_W+WIDTH-1:0]   ts_data,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic [EPOCH_W-1:0]         epoch
);
    logic               event_q;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               cap, pop, accept, full, empty;

    assign cap    = event_in && !event_q && cap_en;
    assign pop    = ts_valid && ts_ready;
    assign accept = cap && (!full || pop);

    always_comb begin
        epoch_d = epoch_q;
        drop_d  = drop_q;
        if (overflow) epoch_d = epoch_q + EPOCH_W'(1);
        if (cap && !accept && drop_q != DROP_MAX) drop_d = drop_q + DROP_W'(1);
    end

    // event_q resets high so a level already asserted at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            event_q <= 1'b1;
            epoch_q <= '0;
            drop_q  <= '0;
        end else begin
            event_q <= event_in;
            epoch_q <= epoch_d;
            drop_q  <= drop_d;
        end
    end

    tscap_fifo #(.DATA_W(EPOCH_W+WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   ({epoch_q, count}),
        .pop   (pop),
        .dout  (ts_data),
        .full  (full),
        .empty (empty),
        .level (fill_level)
    );

    assign ts_valid = !empty;
    assign drop_cnt = drop_q;
    assign epoch    = epoch_q;

endmodule

// File: doc/timestamp_capture.md
Name: timestamp_capture

Overview:
- Downstream consumer of the free-running up counter.
- Samples the counter's `count`/`overflow` outputs on rising edges of a synchronous event input.
- Extends the count with an epoch (wrap) counter and buffers the timestamps in a small FIFO.
- Software/DMA logic drains the FIFO over a valid/ready interface.

Parameters:
- WIDTH, 32: width of the sampled counter value; must match the upstream counter.
- EPOCH_W, 16: width of the epoch (counter wrap) extension.
- DEPTH, 4: FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- count  input  WIDTH  counter value from upstream counter.
- overflow  input  1  upstream wrap flag (count all-ones and counter enabled this cycle).
- event_in  input  1  capture trigger, already synchronous to clk.
- cap_en  input  1  capture enable; edges ignored when low.
- ts_valid  output  1  FIFO head valid.
- ts_ready  input  1  consumer accepts head.
- ts_data  output  EPOCH_W+WIDTH  head timestamp {epoch, count}.
- fill_level  output  $clog2(DEPTH)+1  entries held.
- drop_cnt  output  8  saturating count of edges lost to full FIFO.
- epoch  output  EPOCH_W  current epoch register.

Behaviour:
- Reset is synchronous: rst_n low at a posedge clears FIFO pointers, fill_level=0, ts_valid=0, epoch=0 and drop_cnt=0.
- ts_data is don't-care while ts_valid=0; the bench must not check it.
- Reset loads event_q=1, so event_in held high across reset release produces no capture.
- Edge detect:
  - event_q registers event_in every cycle.
  - An edge occurs in cycle N when event_in=1 and event_q=0.
  - event_q tracks event_in regardless of cap_en.
- Capture: on an edge with cap_en=1, the entry {epoch, count} is formed from the cycle-N values of the epoch register and the count input.
- Epoch:
  - Increments by 1 at the posedge ending any cycle with overflow=1; wraps silently from all-ones to 0.
  - A capture in the same cycle as overflow=1 stores the pre-increment epoch with count all-ones, so it is coherent.
- Push rule: an edge is accepted if fill_level<DEPTH, or if ts_valid&&ts_ready in the same cycle (simultaneous pop+push when full is legal). fill_level is unchanged in that case.
- Drops:
  - An edge that is not accepted with cap_en=1 increments drop_cnt, saturating at 255.
  - Edges with cap_en=0 are not drops.
- FIFO is first-word-fall-through: an edge in cycle N makes ts_valid=1 and presents ts_data in cycle N+1 when the FIFO was empty.
- Pop: occurs on ts_valid&&ts_ready.
  - The head advances next cycle; ts_data must be stable while ts_valid=1 and ts_ready=0.
  - Pop on empty is ignored.
- fill_level: +1 on push only, −1 on pop only, unchanged on both or neither.
- Ordering: strict FIFO order; entries never reordered or duplicated.
- Reset mid-operation discards all buffered entries immediately at that edge; no partial output.

Decomposition:
- Package tscap_pkg holds:
  - localparam TS_W = EPOCH_W+WIDTH (default 48).
  - DROP_W=8 and DROP_MAX=8'hFF.
  - typedef of the timestamp struct {epoch, count}.
- Sub-module tscap_fifo: generic synchronous FWFT FIFO (DATA_W, DEPTH), push/pop/full/empty/level, same synchronous reset.
- Top level holds edge detect, epoch register, drop counter and push qualification.

Test Plan:
- Reset; count=0x00000010, epoch=0, edge with cap_en=1 → next cycle ts_valid=1, ts_data=48'h0000_00000010, fill_level=1.
- Edge coincident with count=0xFFFFFFFF, overflow=1, then an edge at count=0x00000002 → entries {0,0xFFFFFFFF} then {1,0x00000002}; epoch=1.
- ts_ready=0, five edges at counts 1..5 → fill_level=4, drop_cnt=1, drain order 1,2,3,4; ts_data stable while stalled.
- FIFO full, edge with ts_valid&&ts_ready the same cycle → accepted, fill_level stays 4, drop_cnt unchanged, new entry appears last.
- cap_en=0 for 3 edges → no entries, drop_cnt=0; then 300 edges while full with cap_en=1 → drop_cnt=255 (saturated).
- fill_level=3, rst_n low for one edge with event_in held high → next cycle ts_valid=0, fill_level=0, epoch=0, drop_cnt=0; no capture until event_in goes low then high.
